// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, start/DATA bits LSB first/even-XOR parity/stop.
// Outputs are registered and held until the next completed frame.
module uart_rx #(
  parameter int DATA          = 8,
  parameter int CLKS_PER_TICK = 27
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_in,
  output logic [DATA-1:0] rx_data,
  output logic            rx_valid,
  output logic            parity_err,
  output logic            frame_err,
  output logic            rx_busy
);

  localparam int TW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam int BW = $clog2(DATA) + 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA_ST,
    PARITY_ST,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t          state_q, state_d;
  logic            rx_meta_q, rx_meta_d;
  logic            rx_s_q, rx_s_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [3:0]      samp_q, samp_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [DATA-1:0] shift_q, shift_d;
  logic            perr_pend_q, perr_pend_d;
  logic [DATA-1:0] rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            parity_err_q, parity_err_d;
  logic            frame_err_q, frame_err_d;
  logic            rx_busy_q, rx_busy_d;
  logic            tick;
  logic            mid_bit;

  assign tick    = (tick_cnt_q == TICK_LAST);
  assign mid_bit = tick && (samp_q == 4'd15);

  always_comb begin
    rx_meta_d    = rx_in;
    rx_s_d       = rx_meta_q;
    tick_cnt_d   = tick ? '0 : tick_cnt_q + 1'b1;
    state_d      = state_q;
    samp_d       = samp_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    perr_pend_d  = perr_pend_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    rx_busy_d    = rx_busy_q;

    case (state_q)
      IDLE: begin
        if (tick && !rx_s_q) begin
          samp_d    = '0;
          rx_busy_d = 1'b1;
          state_d   = START;
        end
      end
      START: begin
        if (tick) begin
          // Eight ticks after the falling edge lands near the centre of the start bit.
          if (samp_q == 4'd7) begin
            samp_d = '0;
            if (!rx_s_q) begin
              bit_d   = '0;
              state_d = DATA_ST;
            end else begin
              rx_busy_d = 1'b0;
              state_d   = IDLE;
            end
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
      end
      DATA_ST, PARITY_ST, STOP: begin
        if (tick) samp_d = mid_bit ? 4'd0 : samp_q + 1'b1;
        if (mid_bit) begin
          if (state_q == DATA_ST) begin
            shift_d = {rx_s_q, shift_q[DATA-1:1]};
            bit_d   = bit_q + 1'b1;
            if (bit_q == BIT_LAST) state_d = PARITY_ST;
          end else if (state_q == PARITY_ST) begin
            perr_pend_d = rx_s_q ^ (^shift_q);
            state_d     = STOP;
          end else begin
            rx_data_d    = shift_q;
            rx_valid_d   = 1'b1;
            parity_err_d = perr_pend_q;
            frame_err_d  = !rx_s_q;
            if (rx_s_q) begin
              rx_busy_d = 1'b0;
              state_d   = IDLE;
            end else begin
              state_d = WAIT_HIGH;
            end
          end
        end
      end
      WAIT_HIGH: begin
        if (tick && rx_s_q) begin
          rx_busy_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      tick_cnt_q   <= '0;
      samp_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      perr_pend_q  <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_busy_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_meta_q    <= rx_meta_d;
      rx_s_q       <= rx_s_d;
      tick_cnt_q   <= tick_cnt_d;
      samp_q       <= samp_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      perr_pend_q  <= perr_pend_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      rx_busy_q    <= rx_busy_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign rx_busy    = rx_busy_q;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA, default 8, number of data bits per frame.
REQ-002 SHALL have parameter CLKS_PER_TICK, default 27, clk cycles per oversample tick (16 ticks per bit).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rx_in  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port rx_data  output  DATA  last received data word, LSB first on the line.
REQ-007 SHALL have port rx_valid  output  1  one-clk pulse when a frame completes.
REQ-008 SHALL have port parity_err  output  1  error flag for the frame flagged by rx_valid.
REQ-009 SHALL have port frame_err  output  1  stop-bit error flag for the frame flagged by rx_valid.
REQ-010 SHALL have port rx_busy  output  1  high while a frame is being received.

Function
REQ-011 SHALL synchronise rx_in through two flip-flops; all decisions use the second stage (rx_s).
REQ-012 SHALL generate an internal oversample tick: counter 0..CLKS_PER_TICK-1, tick high for one clk when the counter equals CLKS_PER_TICK-1, then wraps to 0.
REQ-013 SHALL accept the frame format: start 0, DATA data bits LSB first, parity bit equal to XOR of the data bits, stop 1.
REQ-014 SHALL implement states IDLE, START, DATA_ST, PARITY_ST, STOP, WAIT_HIGH.
REQ-015 IDLE: on a tick with rx_s=0, clear the sample counter, assert rx_busy, and go to START.
REQ-016 START: on each tick, increment the sample counter; when it reaches 7, sample rx_s. If 0, clear the counter and the bit counter and go to DATA_ST. If 1 (false start), deassert rx_busy and go to IDLE.
REQ-017 DATA_ST/PARITY_ST/STOP: on each tick, increment the sample counter; at 15, sample rx_s and clear the counter.
REQ-018 DATA_ST: each sample shifts into bit position DATA-1 of the shift register and shifts right. After the DATA-th sample, go to PARITY_ST.
REQ-019 PARITY_ST: compute the parity error as sample XOR (XOR of the shift register); go to STOP.
REQ-020 STOP: on the sample, load rx_data from the shift register and pulse rx_valid for exactly one clk. In the same cycle, drive parity_err and frame_err (frame_err = sample==0).
REQ-021 STOP: with sample 1, deassert rx_busy and go to IDLE. With sample 0, go to WAIT_HIGH.
REQ-022 WAIT_HIGH: remain until a tick with rx_s=1, then deassert rx_busy and go to IDLE; no new start is detected while in WAIT_HIGH.
REQ-023 SHALL hold rx_data, parity_err and frame_err until the next rx_valid pulse.
REQ-024 SHALL keep rx_valid low in all cycles other than the STOP sample cycle.
REQ-025 SHALL deliver a frame with errors anyway: rx_valid pulses and the flags qualify the data.
REQ-026 SHALL size the bit counter as $clog2(DATA)+1 bits and the sample counter as 4 bits.
REQ-027 SHALL ignore rx_s glitches between sample points; only mid-bit samples are used.

Reset
REQ-028 With reset high at a clk edge, SHALL set: state IDLE, rx_data 0, rx_valid 0, parity_err 0, frame_err 0, rx_busy 0, all counters 0, synchroniser flops 1.
REQ-029 Reset mid-frame SHALL abort the frame with no rx_valid pulse. Reception SHALL resume only on a new start bit after reset is released.

Verification
REQ-030 CLKS_PER_TICK=4, send 0xA5 with correct parity and stop=1 -> one rx_valid pulse, rx_data=0xA5, parity_err=0, frame_err=0, rx_busy low afterwards.
REQ-031 Send 0x3C with the parity bit inverted -> rx_valid pulse, rx_data=0x3C, parity_err=1, frame_err=0.
REQ-032 Send 0x81 with stop=0, then hold the line low for 3 bit times -> rx_valid pulse, frame_err=1, rx_busy high until the line returns high, no second frame.
REQ-033 Drive a low pulse of 5 ticks on the idle line -> no rx_valid, rx_busy returns to 0 after the START check.
REQ-034 Assert reset at data bit 4 of a frame -> no rx_valid, all outputs 0. The next full frame 0x55 is then received correctly.
REQ-035 Send back-to-back frames 0x00 then 0xFF with no idle gap -> two rx_valid pulses with correct data and no errors.
